// File: rtl/param_data_mem.sv
`default_nettype none
// ============================================================================
// Module   : param_data_mem
// Brief    : Single-port byte-enable data memory with self-clear, req/ready
//            handshake and registered read with valid/error strobes.
// Revision : 1.0
// ============================================================================
module param_data_mem #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req,
  input  logic                  r_w,
  input  logic [ADDR_W-1:0]     address_bus,
  input  logic [DATA_W-1:0]     data_in,
  input  logic [DATA_W/8-1:0]   byte_en,
  output logic                  ready,
  output logic [DATA_W-1:0]     data_out,
  output logic                  rd_valid,
  output logic                  err
);

  localparam int                BE_W    = DATA_W / 8;
  localparam logic [ADDR_W-1:0] C_LAST  = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   C_DEPTH = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [0:0] {
    S_CLEAR = 1'b0,
    S_IDLE  = 1'b1
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_cnt;
  logic                r_ready;
  logic [DATA_W-1:0]   r_data_out;
  logic                r_rd_valid;
  logic                r_err;
  logic [DATA_W-1:0]   r_mem [DEPTH];

  logic                w_accept;
  logic                w_in_range;
  logic                w_wr_en;

  assign w_accept   = req & r_ready;
  assign w_in_range = ({1'b0, address_bus} < C_DEPTH);
  assign w_wr_en    = w_accept & r_w & w_in_range;

  // Reset holds the FSM in CLEAR, so no user write can land while rst_n is low.
  always_ff @(posedge clk) begin
    if (r_state == S_CLEAR) begin
      r_mem[r_cnt] <= '0;
    end else if (w_wr_en) begin
      for (int i = 0; i < BE_W; i++) begin
        if (byte_en[i]) begin
          r_mem[address_bus][8*i +: 8] <= data_in[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_CLEAR;
      r_cnt      <= '0;
      r_ready    <= 1'b0;
      r_data_out <= '0;
      r_rd_valid <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_rd_valid <= 1'b0;
      r_err      <= 1'b0;
      case (r_state)
        S_CLEAR: begin
          r_cnt <= r_cnt + ADDR_W'(1);
          if (r_cnt == C_LAST) begin
            r_state <= S_IDLE;
            r_ready <= 1'b1;
          end
        end
        S_IDLE: begin
          r_ready <= 1'b1;
          if (w_accept) begin
            r_err <= ~w_in_range;
            if (!r_w) begin
              r_rd_valid <= 1'b1;
              r_data_out <= w_in_range ? r_mem[address_bus] : '0;
            end
          end
        end
      endcase
    end
  end

  assign ready    = r_ready;
  assign data_out = r_data_out;
  assign rd_valid = r_rd_valid;
  assign err      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_param_data_mem.sv
`default_nettype none
// ============================================================================
// Module   : tb_param_data_mem
// Brief    : Directed self-checking bench; instance A uses default parameters,
//            instance B uses DATA_W=16, DEPTH=200.
// Revision : 1.0
// ============================================================================
module tb_param_data_mem;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        a_req, a_rw, a_be;
  logic [7:0]  a_addr, a_din;
  logic        a_ready, a_rd_valid, a_err;
  logic [7:0]  a_dout;

  logic        b_req, b_rw;
  logic [1:0]  b_be;
  logic [7:0]  b_addr;
  logic [15:0] b_din;
  logic        b_ready, b_rd_valid, b_err;
  logic [15:0] b_dout;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  param_data_mem u_dut_a (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (a_req),
    .r_w         (a_rw),
    .address_bus (a_addr),
    .data_in     (a_din),
    .byte_en     (a_be),
    .ready       (a_ready),
    .data_out    (a_dout),
    .rd_valid    (a_rd_valid),
    .err         (a_err)
  );

  param_data_mem #(.DATA_W(16), .ADDR_W(8), .DEPTH(200)) u_dut_b (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (b_req),
    .r_w         (b_rw),
    .address_bus (b_addr),
    .data_in     (b_din),
    .byte_en     (b_be),
    .ready       (b_ready),
    .data_out    (b_dout),
    .rd_valid    (b_rd_valid),
    .err         (b_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    else             n_pass++;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drv_a(input logic rq, input logic rw, input logic [7:0] ad,
                       input logic [7:0] d, input logic be);
    a_req = rq; a_rw = rw; a_addr = ad; a_din = d; a_be = be;
  endtask

  task automatic drv_b(input logic rq, input logic rw, input logic [7:0] ad,
                       input logic [15:0] d, input logic [1:0] be);
    b_req = rq; b_rw = rw; b_addr = ad; b_din = d; b_be = be;
  endtask

  // Counts edges after reset release until each instance first shows ready.
  task automatic wait_ready(input string tag);
    int ca = 0;
    int cb = 0;
    for (int c = 1; c <= 400; c++) begin
      cyc();
      if (a_ready && ca == 0) ca = c;
      if (b_ready && cb == 0) cb = c;
      if (ca != 0 && cb != 0) break;
    end
    check({tag, "_clear_cycles_a"}, ca, 256);
    check({tag, "_clear_cycles_b"}, cb, 200);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    drv_a(0, 0, 8'h00, 8'h00, 1'b0);
    drv_b(0, 0, 8'h00, 16'h0000, 2'b00);
    repeat (3) cyc();
    check("rst_ready_a", a_ready, 0);
    check("rst_dout_a",  a_dout, 0);
    check("rst_valid_a", a_rd_valid, 0);
    check("rst_err_a",   a_err, 0);
    check("rst_ready_b", b_ready, 0);
    rst_n = 1'b1;
    wait_ready("t1");

    // T1: read of a cleared word
    drv_a(1, 0, 8'h10, 8'h00, 1'b0);
    cyc();
    check("t1_rd_valid", a_rd_valid, 1);
    check("t1_rd_data",  a_dout, 8'h00);
    check("t1_rd_err",   a_err, 0);
    drv_a(0, 0, 8'h00, 8'h00, 1'b0);
    cyc();
    check("t1_valid_pulse", a_rd_valid, 0);

    // T2: back-to-back writes then reads
    drv_a(1, 1, 8'h00, 8'h01, 1'b1);
    cyc();
    check("t2_wr_novalid", a_rd_valid, 0);
    drv_a(1, 1, 8'h01, 8'h07, 1'b1);
    cyc();
    drv_a(1, 0, 8'h00, 8'h00, 1'b0);
    cyc();
    check("t2_rd0_valid", a_rd_valid, 1);
    check("t2_rd0_data",  a_dout, 8'h01);
    drv_a(1, 0, 8'h01, 8'h00, 1'b0);
    cyc();
    check("t2_rd1_valid", a_rd_valid, 1);
    check("t2_rd1_data",  a_dout, 8'h07);
    drv_a(0, 0, 8'h00, 8'h00, 1'b0);
    cyc();
    check("t2_valid_drop", a_rd_valid, 0);
    check("t2_dout_hold",  a_dout, 8'h07);

    // T3: byte enables on the 16-bit instance
    drv_b(1, 1, 8'd5, 16'hABCD, 2'b11);
    cyc();
    drv_b(1, 1, 8'd5, 16'h1234, 2'b01);
    cyc();
    drv_b(1, 0, 8'd5, 16'h0000, 2'b00);
    cyc();
    check("t3_be01_valid", b_rd_valid, 1);
    check("t3_be01_data",  b_dout, 16'hAB34);
    drv_b(1, 1, 8'd5, 16'hFFFF, 2'b00);
    cyc();
    drv_b(1, 0, 8'd5, 16'h0000, 2'b11);
    cyc();
    check("t3_be00_data", b_dout, 16'hAB34);

    // T4: out-of-range accesses with DEPTH=200
    drv_b(1, 1, 8'd199, 16'h1111, 2'b11);
    cyc();
    check("t4_wr199_err", b_err, 0);
    drv_b(1, 0, 8'd200, 16'h0000, 2'b11);
    cyc();
    check("t4_rd200_valid", b_rd_valid, 1);
    check("t4_rd200_err",   b_err, 1);
    check("t4_rd200_data",  b_dout, 16'h0000);
    drv_b(1, 1, 8'd250, 16'h00FF, 2'b11);
    cyc();
    check("t4_wr250_err",   b_err, 1);
    check("t4_wr250_valid", b_rd_valid, 0);
    drv_b(1, 0, 8'd199, 16'h0000, 2'b11);
    cyc();
    check("t4_rd199_data", b_dout, 16'h1111);
    check("t4_rd199_err",  b_err, 0);
    drv_b(0, 0, 8'd0, 16'h0000, 2'b00);
    cyc();
    check("t4_err_drop", b_err, 0);

    // T5: asynchronous reset mid-operation, with T6 request held across the clear
    drv_a(1, 1, 8'h03, 8'h5A, 1'b1);
    cyc();
    drv_a(1, 0, 8'h03, 8'h00, 1'b0);
    cyc();
    check("t5_pre_data",  a_dout, 8'h5A);
    check("t5_pre_valid", a_rd_valid, 1);
    drv_a(1, 1, 8'h02, 8'h33, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_async_ready", a_ready, 0);
    check("t5_async_dout",  a_dout, 0);
    check("t5_async_valid", a_rd_valid, 0);
    check("t5_async_ready_b", b_ready, 0);
    cyc();
    rst_n = 1'b1;
    wait_ready("t6");
    cyc();
    check("t6_wr_valid", a_rd_valid, 0);
    check("t6_wr_err",   a_err, 0);
    drv_a(1, 0, 8'h03, 8'h00, 1'b0);
    cyc();
    check("t5_recleared_valid", a_rd_valid, 1);
    check("t5_recleared_data",  a_dout, 8'h00);
    drv_a(1, 0, 8'h02, 8'h00, 1'b0);
    cyc();
    check("t6_held_wr_data", a_dout, 8'h33);
    drv_a(0, 0, 8'h00, 8'h00, 1'b0);
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
